board_writer: RTL and testbench
===============================

BOARD_WRITER -- requirements
Module: board_writer

Interface
REQ-001 SHALL have parameter BOARD_BASE, default 12'd64, meaning the dmem word address of board square 0.
REQ-002 SHALL have parameter MAILBOX_ADDR, default 12'd36, meaning the dmem word address of the processor move mailbox.
REQ-003 SHALL have parameter RD_LATENCY, default 2, meaning the iCLK cycles from mem_addr to valid mem_rdata (legal range 1..7).
REQ-004 SHALL have parameter EMPTY_CODE, default 32'd0, meaning the empty-square word.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 SHALL have port iCLK, input, 1 bit: the sole clock.
REQ-007 SHALL have port iRST_n, input, 1 bit: the asynchronous active-low reset.
REQ-008 SHALL have port mv_valid, input, 1 bit: a move request is present.
REQ-009 SHALL have port mv_ready, output, 1 bit: the block accepts a move.
REQ-010 SHALL have port mv_from, input, 6 bits: the source square index.
REQ-011 SHALL have port mv_to, input, 6 bits: the destination square index.
REQ-012 SHALL have port done, output, 1 bit: a one-cycle completion pulse.
REQ-013 SHALL have port err, output, 1 bit: the move was rejected; valid only while done=1.
REQ-014 SHALL have port busy, output, 1 bit: the FSM owns the memory port.
REQ-015 SHALL have port vga_addr, input, 12 bits: the display reader address, passed through when idle.
REQ-016 SHALL have port mem_addr, output, 12 bits: the dmem port-B address.
REQ-017 SHALL have port mem_wdata, output, 32 bits: the dmem port-B write data.
REQ-018 SHALL have port mem_we, output, 1 bit: the dmem port-B write enable.
REQ-019 SHALL have port mem_rdata, input, 32 bits: the dmem port-B read data.

Function
REQ-020 SHALL implement states IDLE, RD, WR_TO, WR_FROM, WR_MAIL and DONE.
REQ-021 SHALL drive mv_ready=1 only in IDLE; a move is accepted on the iCLK edge where mv_valid and mv_ready are both 1, and mv_from and mv_to are captured then.
REQ-022 SHALL, on accept with mv_from==mv_to, go directly to DONE with err=1 and perform no writes.
REQ-023 SHALL otherwise enter RD and hold mem_addr=BOARD_BASE+mv_from (12-bit, modulo 4096) for exactly RD_LATENCY cycles.
REQ-024 SHALL, at the final RD edge, register mem_rdata as piece; if piece==EMPTY_CODE, go to DONE with err=1 and perform no writes.
REQ-025 SHALL, in WR_TO, drive mem_addr=BOARD_BASE+to, mem_wdata=piece and mem_we=1 for one cycle.
REQ-026 SHALL, in WR_FROM, drive mem_addr=BOARD_BASE+from, mem_wdata=EMPTY_CODE and mem_we=1 for one cycle.
REQ-027 SHALL, in WR_MAIL, drive mem_addr=MAILBOX_ADDR, mem_wdata={1'b1, 19'b0, from, to} and mem_we=1 for one cycle.
REQ-028 SHALL, in DONE, assert done=1 for exactly one cycle and return to IDLE on the next cycle.
REQ-029 SHALL, in IDLE, drive mem_addr=vga_addr combinationally, mem_we=0 and busy=0; in all other states busy=1.
REQ-030 SHALL drive mem_we=0 outside WR_TO, WR_FROM and WR_MAIL.
REQ-031 SHALL ignore mv_valid while busy, with no queueing.
REQ-032 SHALL, for a legal move with RD_LATENCY=2, produce done 6 cycles after the accept edge.
REQ-033 SHALL allow a back-to-back request: one held high during DONE is accepted in the following IDLE cycle.

Reset
REQ-034 SHALL, when iRST_n=0, force IDLE immediately, including mid-operation, with mem_we=0, done=0, err=0, busy=0, mv_ready=1, and piece and the latency counter cleared.
REQ-035 SHALL NOT resume an interrupted move after reset; partial writes already issued remain in memory.

Configuration
REQ-036 SHALL include the WR_MAIL state and the mailbox write when macro BOARD_WRITER_MAILBOX_EN is defined.
REQ-037 SHALL, when BOARD_WRITER_MAILBOX_EN is undefined, go from WR_FROM directly to DONE, never write MAILBOX_ADDR, and produce done 5 cycles after accept for RD_LATENCY=2.

Structure
REQ-038 SHALL take the state encoding, EMPTY_CODE default, and mailbox field positions (valid bit 31, from [11:6], to [5:0]) from shared package chess_pkg.
REQ-039 SHALL implement the RD wait as sub-module rd_delay, a 3-bit down-counter with load and zero-flag outputs.

Verification
REQ-040 SHALL verify: piece 32'h49 at square 12, move 12->28 -> square 28 = 32'h49, square 12 = 0, mailbox = 32'h8000_031C, done at accept+6, err=0.
REQ-041 SHALL verify: move 5->5 -> done at accept+1 with err=1 and mem_we never high.
REQ-042 SHALL verify: move from an empty square 40 -> done with err=1 and no writes.
REQ-043 SHALL verify: iRST_n low during WR_TO -> mem_we=0 in the same cycle, busy=0, and mem_addr follows vga_addr.
REQ-044 SHALL verify: idle with vga_addr sweeping 64..127 -> mem_addr equals vga_addr every cycle and mv_ready=1.
REQ-045 SHALL verify: mailbox macro undefined, legal move -> MAILBOX_ADDR unchanged and done at accept+5.

Source files
------------

// File: rtl/chess_pkg.sv
// ---------------------------------------------------------------------------
// chess_pkg: shared FSM encoding, empty-square code and mailbox layout.  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package chess_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_WR_TO   = 3'd2,
    ST_WR_FROM = 3'd3,
    ST_WR_MAIL = 3'd4,
    ST_DONE    = 3'd5
  } bw_state_t;

  localparam logic [31:0] EMPTY_CODE_DEFAULT = 32'd0;
  localparam int          SQ_W               = 6;
  localparam int          MB_VALID_BIT       = 31;
  localparam int          MB_FROM_LSB        = 6;
  localparam int          MB_TO_LSB          = 0;

  function automatic logic [31:0] mailbox_word(input logic [SQ_W-1:0] from_sq,
                                               input logic [SQ_W-1:0] to_sq);
    logic [31:0] w;
    w                           = '0;
    w[MB_VALID_BIT]             = 1'b1;
    w[MB_FROM_LSB +: SQ_W]      = from_sq;
    w[MB_TO_LSB +: SQ_W]        = to_sq;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rd_delay.sv
// ---------------------------------------------------------------------------
// rd_delay: 3-bit loadable down-counter with zero flag for read-latency wait.  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rd_delay (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       en,
  output logic       zero
);

  logic [2:0] cnt_q;
  logic [2:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != 3'd0)) begin
      cnt_d = cnt_q - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == 3'd0);

endmodule

`default_nettype wire

// File: rtl/board_writer.sv
// ---------------------------------------------------------------------------
// board_writer: moves a piece in dmem via port B; mailbox write under
// BOARD_WRITER_MAILBOX_EN.  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module board_writer
  import chess_pkg::*;
#(
  parameter logic [11:0] BOARD_BASE   = 12'd64,
  parameter logic [11:0] MAILBOX_ADDR = 12'd36,
  parameter int          RD_LATENCY   = 2,
  parameter logic [31:0] EMPTY_CODE   = EMPTY_CODE_DEFAULT
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        mv_valid,
  output logic        mv_ready,
  input  logic [5:0]  mv_from,
  input  logic [5:0]  mv_to,
  output logic        done,
  output logic        err,
  output logic        busy,
  input  logic [11:0] vga_addr,
  output logic [11:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] RD_LOAD = 3'(RD_LATENCY - 1);

  bw_state_t   state_q, state_d;
  logic [5:0]  from_q, from_d;
  logic [5:0]  to_q, to_d;
  logic [31:0] piece_q, piece_d;
  logic        err_q, err_d;
  logic        cnt_load;
  logic        cnt_en;
  logic        cnt_zero;

  rd_delay u_rd_delay (
    .clk      (iCLK),
    .rst_n    (iRST_n),
    .load     (cnt_load),
    .load_val (RD_LOAD),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    from_d    = from_q;
    to_d      = to_q;
    piece_d   = piece_q;
    err_d     = err_q;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    mv_ready  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = vga_addr;
    mem_wdata = EMPTY_CODE;

    case (state_q)
      ST_IDLE: begin
        mv_ready = 1'b1;
        busy     = 1'b0;
        if (mv_valid) begin
          from_d   = mv_from;
          to_d     = mv_to;
          err_d    = 1'b0;
          cnt_load = 1'b1;
          if (mv_from == mv_to) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_RD;
          end
        end
      end

      ST_RD: begin
        mem_addr = BOARD_BASE + {6'd0, from_q};
        cnt_en   = 1'b1;
        // Counter reaching zero marks the edge where mem_rdata is valid.
        if (cnt_zero) begin
          piece_d = mem_rdata;
          if (mem_rdata == EMPTY_CODE) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_WR_TO;
          end
        end
      end

      ST_WR_TO: begin
        mem_addr  = BOARD_BASE + {6'd0, to_q};
        mem_wdata = piece_q;
        mem_we    = 1'b1;
        state_d   = ST_WR_FROM;
      end

      ST_WR_FROM: begin
        mem_addr  = BOARD_BASE + {6'd0, from_q};
        mem_wdata = EMPTY_CODE;
        mem_we    = 1'b1;
`ifdef BOARD_WRITER_MAILBOX_EN
        state_d   = ST_WR_MAIL;
`else
        state_d   = ST_DONE;
`endif
      end

      // Unreachable unless the mailbox transition above is compiled in.
      ST_WR_MAIL: begin
        mem_addr  = MAILBOX_ADDR;
        mem_wdata = mailbox_word(from_q, to_q);
        mem_we    = 1'b1;
        state_d   = ST_DONE;
      end

      ST_DONE: begin
        done    = 1'b1;
        err     = err_q;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= ST_IDLE;
      from_q  <= 6'd0;
      to_q    <= 6'd0;
      piece_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      from_q  <= from_d;
      to_q    <= to_d;
      piece_q <= piece_d;
      err_q   <= err_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_board_writer.sv
// ---------------------------------------------------------------------------
// tb_board_writer: table-driven moves against a dmem model plus reset,
// back-to-back and display pass-through sequences.  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_board_writer;

  localparam logic [11:0] BASE     = 12'd64;
  localparam logic [11:0] MBOX     = 12'd36;
  localparam logic [31:0] SENTINEL = 32'hA5A5_0000;
`ifdef BOARD_WRITER_MAILBOX_EN
  localparam int LEGAL_LAT = 6;
  localparam int LEGAL_WR  = 3;
  localparam bit MB_ON     = 1'b1;
`else
  localparam int LEGAL_LAT = 5;
  localparam int LEGAL_WR  = 2;
  localparam bit MB_ON     = 1'b0;
`endif

  logic        iCLK = 1'b0;
  logic        iRST_n = 1'b0;
  logic        mv_valid = 1'b0;
  logic        mv_ready;
  logic [5:0]  mv_from = 6'd0;
  logic [5:0]  mv_to = 6'd0;
  logic        done;
  logic        err;
  logic        busy;
  logic [11:0] vga_addr = 12'd0;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  board_writer dut (
    .iCLK      (iCLK),
    .iRST_n    (iRST_n),
    .mv_valid  (mv_valid),
    .mv_ready  (mv_ready),
    .mv_from   (mv_from),
    .mv_to     (mv_to),
    .done      (done),
    .err       (err),
    .busy      (busy),
    .vga_addr  (vga_addr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  always #5 iCLK = ~iCLK;

  // dmem port-B model: synchronous read one edge after the address (latency 2).
  logic [31:0] mem [0:4095];
  logic [31:0] rdata_q = 32'd0;
  logic        bd_we = 1'b0;
  logic [11:0] bd_addr = 12'd0;
  logic [31:0] bd_data = 32'd0;
  int          we_cnt = 0;

  always @(posedge iCLK) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else if (bd_we) mem[bd_addr] <= bd_data;
    rdata_q <= mem[mem_addr];
    if (mem_we) we_cnt <= we_cnt + 1;
  end
  assign mem_rdata = rdata_q;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [31:0] d);
    @(negedge iCLK);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge iCLK);
    bd_we = 1'b0;
  endtask

  // Called at a negedge; counts negedges (1 = cycle right after the accept edge)
  // until done is seen, sampling err alongside. lat=0 means it never came.
  task automatic wait_done(output int lat, output logic err_seen);
    lat = 0;
    err_seen = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) @(negedge iCLK);
      if (done) begin
        lat = k;
        err_seen = err;
        break;
      end
    end
  endtask

  function automatic logic [11:0] sq(input logic [5:0] s);
    return BASE + {6'd0, s};
  endfunction

  typedef struct {
    logic [5:0]  from;
    logic [5:0]  to;
    logic [31:0] piece;
    logic        exp_err;
    int          exp_lat;
    int          exp_wr;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic        e;
    int          w0;
    logic [31:0] marker;
    logic [31:0] exp_to;
    logic [31:0] exp_from;
    logic [31:0] exp_mb;
    logic        busy_seen;

    vecs[0] = '{6'd12, 6'd28, 32'h0000_0049, 1'b0, LEGAL_LAT, LEGAL_WR};
    vecs[1] = '{6'd5,  6'd5,  32'h0000_0011, 1'b1, 1,         0};
    vecs[2] = '{6'd40, 6'd41, 32'h0000_0000, 1'b1, 3,         0};
    vecs[3] = '{6'd0,  6'd63, 32'hDEAD_BEEF, 1'b0, LEGAL_LAT, LEGAL_WR};
    vecs[4] = '{6'd63, 6'd0,  32'h0000_0005, 1'b0, LEGAL_LAT, LEGAL_WR};

    // Reset state
    vga_addr = 12'h007;
    #2;
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_ready", mv_ready, 1'b1);
    chkb("rst_done", done, 1'b0);
    chkb("rst_we", mem_we, 1'b0);
    chk("rst_addr", {20'd0, mem_addr}, 32'h007);
    @(negedge iCLK);
    iRST_n = 1'b1;
    vga_addr = 12'd0;

    for (int i = 0; i < 5; i++) begin
      marker = 32'h0BAD_0000 | {26'd0, vecs[i].to};
      poke(MBOX, SENTINEL);
      poke(sq(vecs[i].to), marker);
      poke(sq(vecs[i].from), vecs[i].piece);
      w0 = we_cnt;
      @(negedge iCLK);
      chkb($sformatf("v%0d_ready", i), mv_ready, 1'b1);
      mv_valid = 1'b1; mv_from = vecs[i].from; mv_to = vecs[i].to;
      @(posedge iCLK);
      @(negedge iCLK);
      mv_valid = 1'b0;
      wait_done(lat, e);
      chki($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      chkb($sformatf("v%0d_err", i), e, vecs[i].exp_err);
      chki($sformatf("v%0d_writes", i), we_cnt - w0, vecs[i].exp_wr);
      @(negedge iCLK);
      if (vecs[i].exp_err) begin
        exp_from = vecs[i].piece;
        exp_to   = (vecs[i].from == vecs[i].to) ? vecs[i].piece : marker;
        exp_mb   = SENTINEL;
      end else begin
        exp_from = 32'd0;
        exp_to   = vecs[i].piece;
        exp_mb   = MB_ON ? {1'b1, 19'd0, vecs[i].from, vecs[i].to} : SENTINEL;
      end
      chk($sformatf("v%0d_to_sq", i), mem[sq(vecs[i].to)], exp_to);
      chk($sformatf("v%0d_from_sq", i), mem[sq(vecs[i].from)], exp_from);
      chk($sformatf("v%0d_mailbox", i), mem[MBOX], exp_mb);
      chkb($sformatf("v%0d_idle", i), busy, 1'b0);
    end
    if (MB_ON) chk("mailbox_12_28_word", {1'b1, 19'd0, 6'd12, 6'd28}, 32'h8000_031C);

    // Reset asserted while WR_TO drives the write
    poke(MBOX, SENTINEL);
    poke(sq(6'd21), 32'h0000_2121);
    poke(sq(6'd20), 32'h0000_0030);
    @(negedge iCLK);
    mv_valid = 1'b1; mv_from = 6'd20; mv_to = 6'd21;
    @(posedge iCLK);
    @(negedge iCLK);
    mv_valid = 1'b0;
    @(negedge iCLK);
    @(negedge iCLK);
    chkb("wrto_we_before_rst", mem_we, 1'b1);
    chk("wrto_addr_before_rst", {20'd0, mem_addr}, {20'd0, sq(6'd21)});
    w0 = we_cnt;
    vga_addr = 12'h123;
    iRST_n = 1'b0;
    #1;
    chkb("midrst_we", mem_we, 1'b0);
    chkb("midrst_busy", busy, 1'b0);
    chkb("midrst_ready", mv_ready, 1'b1);
    chkb("midrst_done", done, 1'b0);
    chk("midrst_addr", {20'd0, mem_addr}, 32'h123);
    @(negedge iCLK);
    iRST_n = 1'b1;
    busy_seen = 1'b0;
    repeat (6) begin
      @(negedge iCLK);
      if (busy || done || mem_we) busy_seen = 1'b1;
    end
    chkb("norestart_after_rst", busy_seen, 1'b0);
    chki("midrst_writes", we_cnt - w0, 0);
    chk("midrst_to_sq", mem[sq(6'd21)], 32'h0000_2121);
    chk("midrst_mailbox", mem[MBOX], SENTINEL);

    // Back-to-back: request held through the first move and its DONE cycle
    poke(sq(6'd1), 32'h0000_0077);
    poke(sq(6'd2), 32'h0000_0088);
    poke(sq(6'd10), 32'd0);
    poke(sq(6'd11), 32'd0);
    w0 = we_cnt;
    @(negedge iCLK);
    mv_valid = 1'b1; mv_from = 6'd1; mv_to = 6'd10;
    @(posedge iCLK);
    @(negedge iCLK);
    wait_done(lat, e);
    chki("b2b_first_latency", lat, LEGAL_LAT);
    chki("b2b_first_writes", we_cnt - w0, LEGAL_WR);
    mv_from = 6'd2; mv_to = 6'd11;
    @(negedge iCLK);
    chkb("b2b_ready_idle", mv_ready, 1'b1);
    @(posedge iCLK);
    @(negedge iCLK);
    chkb("b2b_busy_after_accept", busy, 1'b1);
    chkb("b2b_not_ready", mv_ready, 1'b0);
    mv_valid = 1'b0;
    wait_done(lat, e);
    chki("b2b_second_latency", lat, LEGAL_LAT);
    chkb("b2b_second_err", e, 1'b0);
    @(negedge iCLK);
    chk("b2b_sq10", mem[sq(6'd10)], 32'h0000_0077);
    chk("b2b_sq11", mem[sq(6'd11)], 32'h0000_0088);
    chk("b2b_sq2", mem[sq(6'd2)], 32'd0);

    // Idle display pass-through sweep
    for (int a = 64; a < 128; a++) begin
      @(negedge iCLK);
      vga_addr = 12'(a);
      #1;
      chk($sformatf("vga_addr_%0d", a), {20'd0, mem_addr}, 32'(a));
      chkb($sformatf("vga_ready_%0d", a), mv_ready, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
